trig_sched: RTL and testbench

Periodic event scheduler built around the `counter` timebase.
- Each of NCH channels selects one trig_out bit (tap) of the counter as its period source; bit k pulses once every 2^(k+1) enabled cycles.
- Triggers latch into per-channel pending flags.
- A round-robin arbiter delivers one event per handshake to a single downstream consumer over a valid/ready interface.

---
 rtl/trig_sched_pkg.sv | 29 ++
 rtl/counter.sv | 24 ++
 rtl/trig_sched.sv | 132 +++++++++++++
 tb/tb_trig_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_sched_pkg.sv
// Shared types, widths and the round-robin pick used by the trig_sched event scheduler.
package trig_sched_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NCH_DEF   = 4;
    localparam int CHW       = $clog2(NCH_DEF);
    localparam int TAPW      = $clog2(WIDTH_DEF);
    localparam int NSLOT     = 1 << CHW;
    localparam int TSLOT     = 1 << TAPW;

    typedef enum logic {IDLE, OFFER} state_t;

    typedef struct packed {
        logic [TAPW-1:0] tap;
        logic            en;
    } chan_cfg_t;

    // First requester at or after ptr, wrapping; slots beyond NCH are always zero.
    function automatic logic [CHW-1:0] rr_pick(input logic [NSLOT-1:0] req,
                                               input logic [CHW-1:0]   ptr);
        logic [CHW-1:0] idx;
        rr_pick = ptr;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            idx = ptr + CHW'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/counter.sv
// Free-running timebase; trig_out[k] pulses for one cycle every 2^(k+1) enabled cycles.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             n_en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] trig_out
);

    always_ff @(posedge clk) begin
        if (!n_rst)
            count <= '0;
        else if (!n_en)
            count <= count + WIDTH'(1);
    end

    // Low bits all ones means the next enabled edge rolls bit k over.
    for (genvar k = 0; k < WIDTH; k++) begin : g_trig
        assign trig_out[k] = ~n_en & (&count[k:0]);
    end

endmodule

// File: rtl/trig_sched.sv
// Periodic event scheduler: per-channel taps on the counter timebase, pending flags, round-robin delivery.
// Optional TRIG_SCHED_OVERRUN_EN adds sticky per-channel overrun flags; otherwise ovr is tied to 0.
module trig_sched
    import trig_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NCH   = NCH_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             n_en,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [TAPW-1:0]  cfg_tap,
    input  logic             cfg_en,
    output logic             ev_valid,
    output logic [CHW-1:0]   ev_ch,
    input  logic             ev_ready,
    output logic [NCH-1:0]   ovr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] trig_out;
    logic [TSLOT-1:0] trig_ext;
    chan_cfg_t        cfg [NCH];
    logic [NCH-1:0]   pending, pending_n, hit, cfg_sel, cfg_clr, fire_clr, avail;
    logic [NSLOT-1:0] avail_pad;
    logic             fire;
    logic [CHW-1:0]   ptr_inc, rr_ptr, rr_ptr_n, ev_ch_n;
    logic             ev_valid_n;
    state_t           state, state_n;

    counter #(.WIDTH(WIDTH)) u_timebase (
        .clk      (clk),
        .n_rst    (n_rst),
        .n_en     (n_en),
        .count    (count),
        .trig_out (trig_out)
    );

    assign fire    = ev_valid & ev_ready;
    assign ptr_inc = (ev_ch == CHW'(NCH - 1)) ? '0 : ev_ch + CHW'(1);

    // Taps at or beyond WIDTH land in the zero padding and never fire.
    always_comb begin
        trig_ext              = '0;
        trig_ext[WIDTH-1:0]   = trig_out;
        avail_pad             = '0;
        for (int c = 0; c < NCH; c++) begin
            hit[c]      = cfg[c].en & trig_ext[cfg[c].tap];
            cfg_sel[c]  = cfg_we & (cfg_ch == CHW'(c));
            cfg_clr[c]  = cfg_sel[c] & ~cfg_en;
            fire_clr[c] = fire & (ev_ch == CHW'(c)) & ~hit[c];
        end
        avail                = pending & ~cfg_clr & ~fire_clr;
        pending_n            = (pending | hit) & ~cfg_clr & ~fire_clr;
        avail_pad[NCH-1:0]   = avail;
    end

    always_comb begin
        state_n    = state;
        ev_valid_n = ev_valid;
        ev_ch_n    = ev_ch;
        rr_ptr_n   = rr_ptr;
        case (state)
            IDLE: begin
                if (|avail) begin
                    state_n    = OFFER;
                    ev_valid_n = 1'b1;
                    ev_ch_n    = rr_pick(avail_pad, rr_ptr);
                end
            end
            OFFER: begin
                if (fire) begin
                    rr_ptr_n = ptr_inc;
                    if (|avail) begin
                        ev_ch_n = rr_pick(avail_pad, ptr_inc);
                    end else begin
                        state_n    = IDLE;
                        ev_valid_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                ev_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            ev_valid <= 1'b0;
            ev_ch    <= '0;
            rr_ptr   <= '0;
            pending  <= '0;
            for (int c = 0; c < NCH; c++) cfg[c] <= '0;
        end else begin
            state    <= state_n;
            ev_valid <= ev_valid_n;
            ev_ch    <= ev_ch_n;
            rr_ptr   <= rr_ptr_n;
            pending  <= pending_n;
            for (int c = 0; c < NCH; c++) begin
                if (cfg_sel[c]) cfg[c] <= '{tap: cfg_tap, en: cfg_en};
            end
        end
    end

`ifdef TRIG_SCHED_OVERRUN_EN
    logic [NCH-1:0] ovr_q, ovr_set;

    // A re-hit on the channel being accepted this cycle is a fresh event, not an overrun.
    always_comb begin
        for (int c = 0; c < NCH; c++)
            ovr_set[c] = hit[c] & pending[c] & ~(fire & (ev_ch == CHW'(c)));
    end

    always_ff @(posedge clk) begin
        if (!n_rst)
            ovr_q <= '0;
        else
            ovr_q <= (ovr_q | ovr_set) & ~cfg_sel;
    end

    assign ovr = ovr_q;
`else
    assign ovr = '0;
`endif

endmodule

// File: tb/tb_trig_sched.sv
// Self-checking bench for trig_sched: a cycle model pushes expected outputs, each edge pops and compares.
module tb_trig_sched;
    import trig_sched_pkg::*;

    localparam int W = 4;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             n_rst, n_en, cfg_we, cfg_en, ev_ready;
    logic [CHW-1:0]   cfg_ch;
    logic [TAPW-1:0]  cfg_tap;
    logic             ev_valid;
    logic [CHW-1:0]   ev_ch;
    logic [N-1:0]     ovr;
    logic [W-1:0]     count;

    typedef struct {
        bit         valid;
        int         ch;
        bit [N-1:0] ovr;
        int         count;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    string      phase    = "init";
    int         grants[N];

    int         m_count = 0;
    bit         m_pend[N];
    bit [N-1:0] m_ovr = '0;
    bit         m_valid = 0;
    int         m_ch = 0;
    int         m_ptr = 0;
    int         m_tap[N];
    bit         m_en[N];

    trig_sched #(.WIDTH(W), .NCH(N)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .n_en     (n_en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_tap  (cfg_tap),
        .cfg_en   (cfg_en),
        .ev_valid (ev_valid),
        .ev_ch    (ev_ch),
        .ev_ready (ev_ready),
        .ovr      (ovr),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Reference behaviour for one clock edge, computed from the inputs currently driven.
    function automatic void model_step();
        bit         trig[W];
        bit         hit[N];
        bit         avail[N];
        bit         npend[N];
        bit [N-1:0] novr;
        bit         fire, wr, clr, found;
        int         start, g, cand;
        exp_t       e;
        if (!n_rst) begin
            m_count = 0; m_ovr = '0; m_valid = 0; m_ch = 0; m_ptr = 0;
            for (int c = 0; c < N; c++) begin
                m_pend[c] = 0; m_tap[c] = 0; m_en[c] = 0;
            end
        end else begin
            for (int k = 0; k < W; k++)
                trig[k] = !n_en && (((m_count + 1) % (1 << (k + 1))) == 0);
            for (int c = 0; c < N; c++)
                hit[c] = (m_en[c] && m_tap[c] < W) ? trig[m_tap[c]] : 1'b0;
            fire = m_valid && ev_ready;
            novr = m_ovr;
            for (int c = 0; c < N; c++) begin
                wr  = cfg_we && (int'(cfg_ch) == c);
                clr = (wr && !cfg_en) || (fire && m_ch == c && !hit[c]);
                avail[c] = m_pend[c] && !clr;
                npend[c] = (m_pend[c] || hit[c]) && !clr;
`ifdef TRIG_SCHED_OVERRUN_EN
                if (hit[c] && m_pend[c] && !(fire && m_ch == c)) novr[c] = 1'b1;
                if (wr) novr[c] = 1'b0;
`endif
            end
            start = m_ptr;
            if (m_valid && fire) begin
                start = (m_ch + 1) % N;
                m_ptr = start;
            end
            found = 0;
            g = 0;
            for (int i = 0; i < N; i++) begin
                cand = (start + i) % N;
                if (!found && avail[cand]) begin
                    found = 1; g = cand;
                end
            end
            if (!m_valid || fire) begin
                if (found) begin
                    m_valid = 1; m_ch = g;
                end else begin
                    m_valid = 0;
                end
            end
            for (int c = 0; c < N; c++) m_pend[c] = npend[c];
            m_ovr = novr;
            if (cfg_we && int'(cfg_ch) < N) begin
                m_tap[int'(cfg_ch)] = int'(cfg_tap);
                m_en[int'(cfg_ch)]  = cfg_en;
            end
            if (!n_en) m_count = (m_count + 1) % (1 << W);
        end
        e.valid = m_valid; e.ch = m_ch; e.ovr = m_ovr; e.count = m_count;
        sb.push_back(e);
    endfunction

    task automatic checkOutput();
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("[TB] FAIL %s scoreboard observed=empty expected=entry", phase);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            assert (ev_valid === e.valid) else begin
                n_fail++;
                $error("[TB] FAIL %s ev_valid observed=%0b expected=%0b", phase, ev_valid, e.valid);
            end
            n_checks++;
            assert (ev_ch === CHW'(e.ch)) else begin
                n_fail++;
                $error("[TB] FAIL %s ev_ch observed=%0d expected=%0d", phase, ev_ch, e.ch);
            end
            n_checks++;
            assert (ovr === e.ovr) else begin
                n_fail++;
                $error("[TB] FAIL %s ovr observed=%b expected=%b", phase, ovr, e.ovr);
            end
            n_checks++;
            assert (count === W'(e.count)) else begin
                n_fail++;
                $error("[TB] FAIL %s count observed=%0d expected=%0d", phase, count, e.count);
            end
        end
        if (ev_valid === 1'b1 && ev_ready === 1'b1 && int'(ev_ch) < N) grants[int'(ev_ch)]++;
    endtask

    task automatic checkValue(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            model_step();
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    task automatic cfgWrite(input int ch, input int tap, input bit en);
        cfg_we  = 1'b1;
        cfg_ch  = CHW'(ch);
        cfg_tap = TAPW'(tap);
        cfg_en  = en;
        applyStimulus(1);
        cfg_we  = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; n_en = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_tap = '0; cfg_en = 1'b0; ev_ready = 1'b0;
        for (int c = 0; c < N; c++) begin
            m_pend[c] = 0; m_tap[c] = 0; m_en[c] = 0; grants[c] = 0;
        end
        @(negedge clk);

        phase = "reset";
        applyStimulus(5);
        checkValue("reset_valid", int'(ev_valid), 0);
        checkValue("reset_count", int'(count), 0);
        checkValue("reset_ovr", int'(ovr), 0);

        phase = "idle";
        n_rst = 1'b1;
        applyStimulus(1);
        checkValue("first_count", int'(count), 1);
        applyStimulus(31);

        phase = "tap_out_of_range";
        cfgWrite(3, 5, 1'b1);
        applyStimulus(20);

        phase = "ch0_tap0";
        ev_ready = 1'b1;
        cfgWrite(0, 0, 1'b1);
        applyStimulus(12);
        cfgWrite(0, 0, 1'b0);
        applyStimulus(4);

        phase = "three_tap1";
        cfgWrite(0, 1, 1'b1);
        cfgWrite(1, 1, 1'b1);
        cfgWrite(2, 1, 1'b1);
        applyStimulus(16);
        cfgWrite(0, 1, 1'b0);
        cfgWrite(1, 1, 1'b0);
        cfgWrite(2, 1, 1'b0);
        applyStimulus(6);

        phase = "overrun";
        ev_ready = 1'b0;
        cfgWrite(0, 0, 1'b1);
        applyStimulus(6);
        checkValue("held_valid", int'(ev_valid), 1);
        checkValue("held_ch", int'(ev_ch), 0);
`ifdef TRIG_SCHED_OVERRUN_EN
        checkValue("ovr0_set", int'(ovr[0]), 1);
`else
        checkValue("ovr0_set", int'(ovr[0]), 0);
`endif
        cfgWrite(0, 0, 1'b1);
        checkValue("ovr0_cleared", int'(ovr[0]), 0);
        applyStimulus(3);
        cfgWrite(0, 0, 1'b0);
        ev_ready = 1'b1;
        applyStimulus(4);

        phase = "alternate";
        cfgWrite(0, 0, 1'b1);
        cfgWrite(1, 0, 1'b1);
        for (int c = 0; c < N; c++) grants[c] = 0;
        applyStimulus(16);
        checkValue("ch0_not_starved", int'(grants[0] >= 3), 1);
        checkValue("ch1_not_starved", int'(grants[1] >= 3), 1);
        cfgWrite(0, 0, 1'b0);
        cfgWrite(1, 0, 1'b0);
        applyStimulus(4);

        phase = "frozen";
        ev_ready = 1'b0;
        cfgWrite(2, 0, 1'b1);
        applyStimulus(3);
        n_en = 1'b1;
        ev_ready = 1'b1;
        applyStimulus(8);
        checkValue("frozen_idle", int'(ev_valid), 0);

        phase = "reset_mid_offer";
        n_en = 1'b0;
        ev_ready = 1'b0;
        applyStimulus(4);
        n_rst = 1'b0;
        applyStimulus(1);
        checkValue("reset_mid_valid", int'(ev_valid), 0);
        n_rst = 1'b1;
        applyStimulus(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
